// File: rtl/tcam_lookup_ctrl_if.sv
// rtl/tcam_lookup_ctrl_if.sv - update, search and result channels of tcam_lookup_ctrl
interface tcam_lookup_ctrl_if #(
  parameter int AW    = 9,
  parameter int WIDTH = 36,
  parameter int TAG_W = 4
);
  logic             upd_valid;
  logic             upd_ready;
  logic [AW-1:0]    upd_addr;
  logic [WIDTH-1:0] upd_patt;
  logic [WIDTH-1:0] upd_mask;
  logic             srch_valid;
  logic             srch_ready;
  logic [WIDTH-1:0] srch_key;
  logic [TAG_W-1:0] srch_tag;
  logic             res_valid;
  logic             res_ready;
  logic             res_hit;
  logic [AW-1:0]    res_addr;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output upd_valid, upd_addr, upd_patt, upd_mask,
    output srch_valid, srch_key, srch_tag,
    output res_ready,
    input  upd_ready, srch_ready,
    input  res_valid, res_hit, res_addr, res_tag
  );

  modport slave (
    input  upd_valid, upd_addr, upd_patt, upd_mask,
    input  srch_valid, srch_key, srch_tag,
    input  res_ready,
    output upd_ready, srch_ready,
    output res_valid, res_hit, res_addr, res_tag
  );
endinterface

// File: rtl/tcam_lookup_ctrl.sv
// rtl/tcam_lookup_ctrl.sv - arbitrates rule updates and searches onto a TCAM port, returns tagged results in order
module tcam_lookup_ctrl #(
  parameter int  DEPTH     = 512,
  parameter int  WIDTH     = 36,
  parameter int  TAG_W     = 4,
  parameter int  RES_DEPTH = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  tcam_lookup_ctrl_if.slave lk,
  output logic             tcam_wEn,
  output logic [AW-1:0]    tcam_wAddr,
  output logic [WIDTH-1:0] tcam_wPatt,
  output logic [WIDTH-1:0] tcam_wMask,
  output logic [WIDTH-1:0] tcam_mPatt,
  input  logic             tcam_match,
  input  logic [AW-1:0]    tcam_mAddr,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + AW + TAG_W;

  typedef enum logic {GR_SRCH = 1'b0, GR_UPD = 1'b1} grant_e;

  grant_e           last_grant, last_grant_nx;
  logic             srch_ok, srch_elig, upd_go, srch_go;
  logic             inflight;
  logic [TAG_W-1:0] tag_q;
  logic [EW-1:0]    fifo_mem [RES_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic             push, pop;
  logic [EW-1:0]    push_data;
  logic             head_hit;
  logic [AW-1:0]    head_addr;
  logic [TAG_W-1:0] head_tag;
  logic [AW-1:0]    waddr_q;
  logic [WIDTH-1:0] wpatt_q, wmask_q, mpatt_q;

  // A slot is reserved for the in-flight search so the FIFO can never overflow.
  assign srch_ok   = (fifo_count + CW'(inflight)) < CW'(RES_DEPTH);
  assign srch_elig = lk.srch_valid && srch_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= GR_SRCH;
    else        last_grant <= last_grant_nx;
  end

  // Readies are "would be granted if valid", so neither depends on its own valid.
  always_comb begin
    last_grant_nx = last_grant;
    lk.upd_ready  = 1'b0;
    lk.srch_ready = 1'b0;
    if (rst_n) begin
      lk.upd_ready  = !srch_elig || (last_grant == GR_SRCH);
      lk.srch_ready = srch_ok && (!lk.upd_valid || (last_grant == GR_UPD));
    end
    upd_go  = lk.upd_valid && lk.upd_ready;
    srch_go = lk.srch_valid && lk.srch_ready;
    if (upd_go)       last_grant_nx = GR_UPD;
    else if (srch_go) last_grant_nx = GR_SRCH;
  end

  assign tcam_wEn   = upd_go;
  assign tcam_wAddr = upd_go ? lk.upd_addr : waddr_q;
  assign tcam_wPatt = upd_go ? lk.upd_patt : wpatt_q;
  assign tcam_wMask = upd_go ? lk.upd_mask : wmask_q;
  assign tcam_mPatt = (upd_go || srch_go) ? lk.srch_key : mpatt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      wpatt_q  <= '0;
      wmask_q  <= '0;
      mpatt_q  <= '0;
      inflight <= 1'b0;
      tag_q    <= '0;
    end else begin
      if (upd_go) begin
        waddr_q <= lk.upd_addr;
        wpatt_q <= lk.upd_patt;
        wmask_q <= lk.upd_mask;
      end
      if (upd_go || srch_go) mpatt_q <= lk.srch_key;
      inflight <= srch_go;
      if (srch_go) tag_q <= lk.srch_tag;
    end
  end

  // The CAM answers one cycle after the search was presented.
  assign push      = inflight;
  assign push_data = {tcam_match, tcam_match ? tcam_mAddr : {AW{1'b0}}, tag_q};
  assign pop       = lk.res_valid && lk.res_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign {head_hit, head_addr, head_tag} = fifo_mem[rd_ptr];
  assign lk.res_valid = (fifo_count != '0);
  assign lk.res_hit   = lk.res_valid && head_hit;
  assign lk.res_addr  = lk.res_valid ? head_addr : '0;
  assign lk.res_tag   = lk.res_valid ? head_tag : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (push) begin
      if (tcam_match) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb/tb_tcam_lookup_ctrl.sv - directed bench for tcam_lookup_ctrl with a 1-cycle CAM model
`timescale 1ns/1ps
module tb_tcam_lookup_ctrl;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int WIDTH = 36;
  localparam int TAG_W = 4;
  localparam logic [35:0] KA   = 36'h1_2345_6789;
  localparam logic [35:0] KB   = 36'hA_BCDE_F012;
  localparam logic [35:0] KC   = 36'h5_5555_5555;
  localparam logic [35:0] MALL = 36'hF_FFFF_FFFF;

  typedef struct packed {logic hit; logic [AW-1:0] addr; logic [TAG_W-1:0] tag;} res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tcam_wEn;
  logic [AW-1:0]    tcam_wAddr;
  logic [WIDTH-1:0] tcam_wPatt, tcam_wMask, tcam_mPatt;
  logic             tcam_match = 1'b0;
  logic [AW-1:0]    tcam_mAddr = '0;
  logic [15:0]      hit_cnt, miss_cnt;

  logic [WIDTH-1:0] tpatt [DEPTH];
  logic [WIDTH-1:0] tmask [DEPTH];
  bit               tvld  [DEPTH];

  res_t res_q[$];
  int   wen_cnt = 0;
  bit   mon_en  = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   acc, w0;
  res_t cur;

  tcam_lookup_ctrl_if #(.AW(AW), .WIDTH(WIDTH), .TAG_W(TAG_W)) lk ();

  tcam_lookup_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W), .RES_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .lk(lk),
    .tcam_wEn(tcam_wEn), .tcam_wAddr(tcam_wAddr), .tcam_wPatt(tcam_wPatt),
    .tcam_wMask(tcam_wMask), .tcam_mPatt(tcam_mPatt),
    .tcam_match(tcam_match), .tcam_mAddr(tcam_mAddr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit cam_hit(input logic [WIDTH-1:0] k);
    for (int i = 0; i < DEPTH; i++)
      if (tvld[i] && (((k ^ tpatt[i]) & tmask[i]) == '0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] cam_addr(input logic [WIDTH-1:0] k);
    for (int i = 0; i < DEPTH; i++)
      if (tvld[i] && (((k ^ tpatt[i]) & tmask[i]) == '0)) return AW'(i);
    return 9'h1FF;
  endfunction

  // Mask bit 1 = compare; a miss drives a nonzero address the DUT must zero.
  always @(posedge clk) begin
    tcam_match <= cam_hit(tcam_mPatt);
    tcam_mAddr <= cam_addr(tcam_mPatt);
    if (tcam_wEn) begin
      tpatt[tcam_wAddr] <= tcam_wPatt;
      tmask[tcam_wAddr] <= tcam_wMask;
      tvld[tcam_wAddr]  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en && lk.res_valid && lk.res_ready)
      res_q.push_back({lk.res_hit, lk.res_addr, lk.res_tag});
    if (tcam_wEn) wen_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_upd(input logic [AW-1:0] a, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    int n = 0;
    @(negedge clk);
    lk.upd_valid = 1'b1; lk.upd_addr = a; lk.upd_patt = p; lk.upd_mask = m;
    #1;
    while (!lk.upd_ready && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("upd_wait", n < 50, 1);
    @(negedge clk);
    lk.upd_valid = 1'b0;
  endtask

  task automatic do_srch(input logic [WIDTH-1:0] k, input logic [TAG_W-1:0] t);
    int n = 0;
    @(negedge clk);
    lk.srch_valid = 1'b1; lk.srch_key = k; lk.srch_tag = t;
    #1;
    while (!lk.srch_ready && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("srch_wait", n < 50, 1);
    @(negedge clk);
    lk.srch_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic h, input logic [AW-1:0] a, input logic [TAG_W-1:0] t);
    int n = 0;
    res_t r;
    while (res_q.size() == 0 && n < 30) begin @(negedge clk); n++; end
    check_eq({tag, "_arrive"}, res_q.size() != 0, 1);
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      check_eq(tag, r, {h, a, t});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lk.upd_valid = 1'b1; lk.upd_addr = '0; lk.upd_patt = '0; lk.upd_mask = '0;
    lk.srch_valid = 1'b1; lk.srch_key = '0; lk.srch_tag = '0; lk.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_wen", tcam_wEn, 0);
    check_eq("rst_res_valid", lk.res_valid, 0);
    check_eq("rst_readies", {lk.upd_ready, lk.srch_ready}, 2'b00);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);
    lk.upd_valid = 1'b0; lk.srch_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // single hit: latency and hold while stalled
    do_upd(9'd37, KA, MALL);
    @(negedge clk);
    lk.srch_valid = 1'b1; lk.srch_key = KA; lk.srch_tag = 4'd5;
    #1;
    check_eq("t1_srch_ready", lk.srch_ready, 1);
    check_eq("t1_mpatt", tcam_mPatt, KA);
    check_eq("t1_wen", tcam_wEn, 0);
    @(negedge clk);
    lk.srch_valid = 1'b0;
    #1;
    check_eq("t1_lat1", lk.res_valid, 0);
    @(negedge clk);
    #1;
    check_eq("t1_lat2", lk.res_valid, 1);
    check_eq("t1_res", {lk.res_hit, lk.res_addr, lk.res_tag}, {1'b1, 9'd37, 4'd5});
    check_eq("t1_hit_cnt", hit_cnt, 1);
    @(negedge clk);
    #1;
    check_eq("t1_hold", {lk.res_valid, lk.res_hit, lk.res_addr, lk.res_tag}, {2'b11, 9'd37, 4'd5});
    lk.res_ready = 1'b1;
    expect_res("t1_pop", 1'b1, 9'd37, 4'd5);

    // update then search next cycle sees the new rule
    @(negedge clk);
    lk.upd_valid = 1'b1; lk.upd_addr = 9'd9; lk.upd_patt = KB; lk.upd_mask = MALL;
    lk.srch_valid = 1'b1; lk.srch_key = KB; lk.srch_tag = 4'd7;
    #1;
    check_eq("t2_upd_first", {lk.upd_ready, lk.srch_ready}, 2'b10);
    check_eq("t2_waddr", tcam_wAddr, 9'd9);
    @(negedge clk);
    lk.upd_valid = 1'b0;
    #1;
    check_eq("t2_srch_next", lk.srch_ready, 1);
    @(negedge clk);
    lk.srch_valid = 1'b0;
    expect_res("t2_res", 1'b1, 9'd9, 4'd7);
    check_eq("t2_hit_cnt", hit_cnt, 2);

    // both channels busy: strict alternation
    w0 = wen_cnt;
    @(negedge clk);
    lk.upd_valid = 1'b1; lk.upd_addr = 9'd100; lk.upd_patt = 36'hF_0000_0000; lk.upd_mask = MALL;
    lk.srch_valid = 1'b1; lk.srch_key = KA;
    for (int i = 0; i < 8; i++) begin
      lk.srch_tag = 4'(i);
      #1;
      check_eq($sformatf("t3_grant%0d", i), {lk.upd_ready, lk.srch_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    lk.upd_valid = 1'b0; lk.srch_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_res($sformatf("t3_res%0d", i), 1'b1, 9'd37, 4'(2 * i + 1));
    check_eq("t3_wen_pulses", wen_cnt - w0, 4);
    check_eq("t3_hit_cnt", hit_cnt, 6);

    // stalled consumer: credits cap acceptance at 4
    @(negedge clk);
    lk.res_ready = 1'b0; lk.srch_valid = 1'b1; lk.srch_key = KA;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      lk.srch_tag = 4'(acc);
      #1;
      check_eq($sformatf("t4_ready%0d", i), lk.srch_ready, i < 4);
      if (lk.srch_ready) acc++;
      @(negedge clk);
    end
    check_eq("t4_accepted", acc, 4);
    lk.upd_valid = 1'b1; lk.upd_addr = 9'd200; lk.upd_patt = '0; lk.upd_mask = MALL;
    #1;
    check_eq("t4_full_readies", {lk.upd_ready, lk.srch_ready, tcam_wEn}, 3'b101);
    @(negedge clk);
    lk.upd_valid = 1'b0; lk.srch_valid = 1'b0;
    lk.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_res($sformatf("t4_pop%0d", i), 1'b1, 9'd37, 4'(i));
    do_srch(KA, 4'd9);
    expect_res("t4_resume", 1'b1, 9'd37, 4'd9);
    check_eq("t4_hit_cnt", hit_cnt, 11);

    // miss
    do_srch(KC, 4'd3);
    expect_res("t5_miss", 1'b0, 9'd0, 4'd3);
    check_eq("t5_miss_cnt", miss_cnt, 1);
    check_eq("t5_hit_cnt", hit_cnt, 11);

    // reset with two results queued and one search in flight
    @(negedge clk);
    lk.res_ready = 1'b0;
    do_srch(KA, 4'd1);
    do_srch(KA, 4'd2);
    @(negedge clk);
    lk.srch_valid = 1'b1; lk.srch_key = KA; lk.srch_tag = 4'd3;
    #1;
    check_eq("t6_pre_state", {lk.srch_ready, lk.res_valid}, 2'b11);
    @(negedge clk);
    lk.srch_valid = 1'b0; lk.upd_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_res_valid", lk.res_valid, 0);
    check_eq("t6_rst_wen", tcam_wEn, 0);
    check_eq("t6_rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; lk.upd_valid = 1'b0;
    lk.res_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check_eq("t6_no_stale", res_q.size(), 0);
    check_eq("t6_res_valid", lk.res_valid, 0);
    check_eq("t6_hit_cnt", hit_cnt, 0);

    // hit counter saturation
    mon_en = 1'b0;
    @(negedge clk);
    lk.srch_valid = 1'b1; lk.srch_key = KA; lk.srch_tag = 4'd0;
    acc = 0;
    for (int i = 0; i < 70000 && acc < 65534; i++) begin
      #1;
      if (lk.srch_ready) acc++;
      @(negedge clk);
    end
    lk.srch_valid = 1'b0;
    check_eq("t7_accepted", acc, 65534);
    repeat (4) @(negedge clk);
    #1;
    check_eq("t7_hit_fffe", hit_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) do_srch(KA, 4'(i));
    repeat (4) @(negedge clk);
    #1;
    check_eq("t7_hit_sat", hit_cnt, 16'hFFFF);
    check_eq("t7_miss_cnt", miss_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
